// File: rtl/mips_mmio_pkg.sv
// rtl/mips_mmio_pkg.sv - register offsets, STATUS bit positions and FSM states for MMIO peripherals
package mips_mmio_pkg;

  localparam logic [1:0] UART_DATA_OFS   = 2'd0;
  localparam logic [1:0] UART_STATUS_OFS = 2'd1;
  localparam logic [1:0] UART_DIV_OFS    = 2'd2;

  localparam int UART_ST_BUSY    = 0;
  localparam int UART_ST_FULL    = 1;
  localparam int UART_ST_EMPTY   = 2;
  localparam int UART_ST_OVF     = 3;
  localparam int UART_ST_CNT_LSB = 4;
  localparam int UART_ST_CNT_MSB = 7;
  localparam int UART_ST_PAR     = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

endpackage

// File: rtl/mmio_tx_fifo.sv
// rtl/mmio_tx_fifo.sv - byte-wide synchronous FIFO feeding the UART frame FSM
module mmio_tx_fifo #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [7:0]    wdata,
  input  logic          pop,
  output logic [7:0]    rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (push) wp_d = wp_q + 1'b1;
    if (pop)  rp_d = rp_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: only slots between rp and wp are ever observed.
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= wdata;
  end

  assign rdata = mem_q[rp_q];
  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;

endmodule

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - MMIO UART transmitter on the MIPS data bus (8N1, LSB first)
// Optional even-parity bit between data and stop when MMIO_UART_TX_PARITY_EN is defined.
module mmio_uart_tx
  import mips_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0100,
  parameter int          DEPTH       = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        WE,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Sel,
  output logic        tx
);

  localparam int CW = $clog2(DEPTH) + 1;

  uart_tx_state_t state_q, state_d;
  logic [15:0] csr_div_q, csr_div_d, div_q, div_d, baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        ovf_q, ovf_d, tx_q, tx_d;
  logic        par_q, par_d;
  logic [1:0]  ofs;
  logic        wr, push_req, push_ok, tc, load;
  logic        fifo_pop, fifo_full, fifo_empty;
  logic [7:0]  fifo_rdata;
  logic [CW-1:0] fifo_count;
  logic [31:0] status;
  logic        unused_bits;

  assign Sel         = (Address[31:4] == BASE_ADDR[31:4]);
  assign ofs         = Address[3:2];
  assign wr          = WE && Sel;
  assign push_req    = wr && (ofs == UART_DATA_OFS);
  // A push into a full FIFO still lands when the FSM frees a slot on the same edge.
  assign push_ok     = push_req && (!fifo_full || fifo_pop);
  assign unused_bits = ^{Address[1:0], WriteData[31:16]};

  mmio_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_ok),
    .wdata (WriteData[7:0]),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    csr_div_d = csr_div_q;
    ovf_d     = ovf_q;
    if (wr && ofs == UART_DIV_OFS) csr_div_d = WriteData[15:0];
    if (wr && ofs == UART_STATUS_OFS && WriteData[UART_ST_OVF]) ovf_d = 1'b0;
    if (push_req && fifo_full && !fifo_pop) ovf_d = 1'b1;
  end

  always_comb begin
    tc       = (baud_q == div_q);
    state_d  = state_q;
    div_d    = div_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    par_d    = par_q;
    fifo_pop = 1'b0;
    load     = 1'b0;
    baud_d   = (state_q == IDLE || tc) ? '0 : baud_q + 16'd1;
    case (state_q)
      IDLE:  load = !fifo_empty;
      START: if (tc) begin
        state_d = DATA;
        bit_d   = '0;
      end
      DATA: if (tc) begin
        shift_d = {1'b0, shift_q[7:1]};
        if (bit_q == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end else begin
          bit_d = bit_q + 3'd1;
        end
      end
`ifdef MMIO_UART_TX_PARITY_EN
      PARITY: if (tc) state_d = STOP;
`endif
      STOP: if (tc) begin
        if (!fifo_empty) load = 1'b1;
        else state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // The divisor is sampled once per frame so mid-frame DIV writes only affect the next one.
    if (load) begin
      fifo_pop = 1'b1;
      shift_d  = fifo_rdata;
      par_d    = ^fifo_rdata;
      div_d    = csr_div_q;
      state_d  = START;
      baud_d   = '0;
      bit_d    = '0;
    end
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef MMIO_UART_TX_PARITY_EN
      PARITY:  tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      csr_div_q <= DEFAULT_DIV;
      div_q     <= DEFAULT_DIV;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      ovf_q     <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      csr_div_q <= csr_div_d;
      div_q     <= div_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      ovf_q     <= ovf_d;
      tx_q      <= tx_d;
    end
  end

  always_comb begin
    status                                  = '0;
    status[UART_ST_BUSY]                    = (state_q != IDLE);
    status[UART_ST_FULL]                    = fifo_full;
    status[UART_ST_EMPTY]                   = fifo_empty;
    status[UART_ST_OVF]                     = ovf_q;
    status[UART_ST_CNT_MSB:UART_ST_CNT_LSB] = 4'(fifo_count);
`ifdef MMIO_UART_TX_PARITY_EN
    status[UART_ST_PAR]                     = 1'b1;
`endif
  end

  always_comb begin
    ReadData = '0;
    if (Sel) begin
      case (ofs)
        UART_STATUS_OFS: ReadData = status;
        UART_DIV_OFS:    ReadData = {16'b0, csr_div_q};
        default:         ReadData = '0;
      endcase
    end
  end

  assign tx = tx_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - self-checking bench for mmio_uart_tx: register table, frame receiver model, corner sequences
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'h0000_0100;
`ifdef MMIO_UART_TX_PARITY_EN
  localparam int          NB      = 11;
  localparam logic [31:0] ST_IDLE = 32'h0000_0104;
`else
  localparam int          NB      = 10;
  localparam logic [31:0] ST_IDLE = 32'h0000_0004;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        WE = 1'b0;
  logic [31:0] Address = '0;
  logic [31:0] WriteData = '0;
  logic [31:0] ReadData;
  logic        Sel;
  logic        tx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mmio_uart_tx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .WE        (WE),
    .Address   (Address),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .Sel       (Sel),
    .tx        (tx)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_sel;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask

  // Reference frame: start 0, data LSB first, optional even parity, stop 1.
  function automatic logic [10:0] frame_bits(input logic [7:0] b);
    logic [10:0] f;
    f = '0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
`ifdef MMIO_UART_TX_PARITY_EN
    f[9] = ^b;
`endif
    f[NB-1] = 1'b1;
    return f;
  endfunction

  task automatic wr(input logic [3:0] ofs, input logic [31:0] d);
    Address   = BASE + {28'b0, ofs};
    WriteData = d;
    WE        = 1'b1;
    @(negedge clk);
    WE        = 1'b0;
  endtask

  task automatic rd(input logic [3:0] ofs, output logic [31:0] v);
    WE      = 1'b0;
    Address = BASE + {28'b0, ofs};
    #1;
    v = ReadData;
  endtask

  task automatic wait_start(input string nm);
    int t;
    t = 0;
    while (tx !== 1'b0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    check(nm, {31'b0, tx === 1'b0}, 32'd1);
  endtask

  // Samples every cycle of a frame; the first sample is taken at the current time.
  task automatic rx_frame(input int d, input logic [7:0] b, input string nm);
    logic [10:0] got;
    logic        stable;
    logic        v;
    int          s;
    got = '0;
    stable = 1'b1;
    s = 0;
    for (int k = 0; k < NB; k++) begin
      for (int c = 0; c <= d; c++) begin
        if (s > 0) @(negedge clk);
        s++;
        v = tx;
        if (c == 0) got[k] = v;
        else if (v !== got[k]) stable = 1'b0;
      end
    end
    check(nm, {21'b0, got}, {21'b0, frame_bits(b)});
    check(nm, {31'b0, stable}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    vec_t        tbl[15];
    logic [31:0] v;
    logic [7:0]  q[$];
    logic        saw_low;
    int          d, n;

    tbl[0]  = '{1'b0, 32'h104, 32'h0,         ST_IDLE,      1'b1};
    tbl[1]  = '{1'b0, 32'h108, 32'h0,         32'd433,      1'b1};
    tbl[2]  = '{1'b0, 32'h100, 32'h0,         32'h0,        1'b1};
    tbl[3]  = '{1'b0, 32'h10C, 32'h0,         32'h0,        1'b1};
    tbl[4]  = '{1'b0, 32'h200, 32'h0,         32'h0,        1'b0};
    tbl[5]  = '{1'b0, 32'h0FC, 32'h0,         32'h0,        1'b0};
    tbl[6]  = '{1'b1, 32'h108, 32'hABCD_1234, 32'd433,      1'b1};
    tbl[7]  = '{1'b0, 32'h108, 32'h0,         32'h1234,     1'b1};
    tbl[8]  = '{1'b1, 32'h10C, 32'hFFFF_FFFF, 32'h0,        1'b1};
    tbl[9]  = '{1'b1, 32'h208, 32'h5,         32'h0,        1'b0};
    tbl[10] = '{1'b0, 32'h108, 32'h0,         32'h1234,     1'b1};
    tbl[11] = '{1'b1, 32'h104, 32'hFFFF_FFFF, ST_IDLE,      1'b1};
    tbl[12] = '{1'b0, 32'h104, 32'h0,         ST_IDLE,      1'b1};
    tbl[13] = '{1'b1, 32'h108, 32'd433,       32'h1234,     1'b1};
    tbl[14] = '{1'b0, 32'h108, 32'h0,         32'd433,      1'b1};

    repeat (3) @(negedge clk);
    check("tx_in_reset", {31'b0, tx}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      WE = tbl[i].we;
      Address = tbl[i].addr;
      WriteData = tbl[i].wdata;
      #1;
      check($sformatf("tbl%0d_rd", i), ReadData, tbl[i].exp_rd);
      check($sformatf("tbl%0d_sel", i), {31'b0, Sel}, {31'b0, tbl[i].exp_sel});
      @(negedge clk);
    end
    WE = 1'b0;
    check("tx_idle_after_reset", {31'b0, tx}, 32'd1);

    // 0x55 at DIV=3: start one edge after the store, 4 cycles per bit.
    wr(4'h8, 32'd3);
    wr(4'h0, 32'h55);
    check("tx_high_at_store_edge", {31'b0, tx}, 32'd1);
    @(negedge clk);
    rx_frame(3, 8'h55, "frame_55");
    rd(4'h4, v);
    check("busy_in_last_stop_cycle", {31'b0, v[0]}, 32'd1);
    @(negedge clk);
    rd(4'h4, v);
    check("idle_after_frame_55", v, ST_IDLE);

    // Fill, overflow, W1C, then a push on the pop edge of a full FIFO.
    @(negedge clk);
    wr(4'h8, 32'd0);
    q = '{8'hA0, 8'h0F, 8'h11, 8'h22, 8'h33, 8'h5A};
    fork
      begin
        wr(4'h0, 32'hA0);
        wr(4'h0, 32'h0F);
        wr(4'h0, 32'h11);
        wr(4'h0, 32'h22);
        wr(4'h0, 32'h33);
        rd(4'h4, v);
        check("full_no_ovf", {24'b0, v[7:0]}, 32'h43);
        wr(4'h0, 32'h99);
        rd(4'h4, v);
        check("ovf_set", {24'b0, v[7:0]}, 32'h4B);
        wr(4'h4, 32'h8);
        rd(4'h4, v);
        check("ovf_cleared", {24'b0, v[7:0]}, 32'h43);
        repeat (NB - 6) @(negedge clk);
        wr(4'h0, 32'h5A);
        rd(4'h4, v);
        check("push_on_pop_accepted", {24'b0, v[7:0]}, 32'h43);
      end
      begin
        wait_start("start_ovf_seq");
        for (int i = 0; i < 6; i++) begin
          if (i > 0) @(negedge clk);
          rx_frame(0, q[i], $sformatf("ovf_seq_frame%0d", i));
        end
        saw_low = 1'b0;
        repeat (15) begin
          @(negedge clk);
          if (tx !== 1'b1) saw_low = 1'b1;
        end
        check("no_dropped_byte_sent", {31'b0, saw_low}, 32'd0);
      end
    join

    // DIV change mid-frame takes effect on the following frame only.
    @(negedge clk);
    wr(4'h8, 32'd1);
    fork
      begin
        wr(4'h0, 32'hC3);
        wr(4'h0, 32'h3C);
        repeat (5) @(negedge clk);
        wr(4'h8, 32'd7);
      end
      begin
        wait_start("start_div_seq");
        rx_frame(1, 8'hC3, "div1_frame");
        @(negedge clk);
        rx_frame(7, 8'h3C, "div7_frame");
        @(negedge clk);
        check("idle_after_div_seq", {31'b0, tx}, 32'd1);
      end
    join

    // 0x07 has odd weight: parity bit 1 when the parity build is selected.
    @(negedge clk);
    wr(4'h8, 32'd2);
    fork
      wr(4'h0, 32'h07);
      begin
        wait_start("start_07");
        rx_frame(2, 8'h07, "frame_07");
      end
    join
    @(negedge clk);
    rd(4'h4, v);
    check("status_after_07", v, ST_IDLE);

    for (int it = 0; it < 6; it++) begin
      @(negedge clk);
      d = $urandom_range(0, 4);
      n = $urandom_range(1, 5);
      q.delete();
      for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
      wr(4'h8, 32'(d));
      fork
        begin
          for (int i = 0; i < n; i++) begin
            wr(4'h0, {24'b0, q[i]});
            repeat ($urandom_range(0, 1)) @(negedge clk);
          end
        end
        begin
          wait_start($sformatf("rand%0d_start", it));
          for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            rx_frame(d, q[i], $sformatf("rand%0d_frame%0d_div%0d", it, i, d));
          end
        end
      join
      @(negedge clk);
      rd(4'h4, v);
      check($sformatf("rand%0d_idle", it), v, ST_IDLE);
    end

    // Asynchronous reset in the middle of a data bit.
    @(negedge clk);
    wr(4'h8, 32'd3);
    wr(4'h0, 32'h00);
    wr(4'h0, 32'h00);
    wr(4'h0, 32'h00);
    repeat (8) @(negedge clk);
    check("tx_low_mid_data", {31'b0, tx}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("tx_async_reset", {31'b0, tx}, 32'd1);
    rd(4'h4, v);
    check("fifo_flushed_in_reset", v, ST_IDLE);
    rd(4'h8, v);
    check("div_default_in_reset", v, 32'd433);
    @(negedge clk);
    rst_n = 1'b1;
    saw_low = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (tx !== 1'b1) saw_low = 1'b1;
    end
    check("no_frame_after_reset", {31'b0, saw_low}, 32'd0);
    rd(4'h4, v);
    check("status_after_reset", v, ST_IDLE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter that acts as a responder on the MIPS core's data-memory bus (Address/WriteData/WE/ReadData), alongside Data_Memory. Stores from the core to its address window push bytes into a small TX FIFO, set the baud divisor, or clear status. Loads return status combinationally in the same cycle, so the single-cycle core sees them. A frame FSM serialises FIFO bytes onto `tx`, 8N1, LSB first.

## Interface
- `BASE_ADDR`, 32'h0000_0100: window base. Decode compares `Address[31:4]` with `BASE_ADDR[31:4]`.
- `DEPTH`, 4: FIFO entries, a power of two ≥ 2.
- `DEFAULT_DIV`, 16'd433: reset value of the divisor. Each bit lasts DIV+1 cycles.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `WE`  in  1  store strobe from the core (MemWrite).
- `Address`  in  32  byte address from the core (ALUOut).
- `WriteData`  in  32  store data.
- `ReadData`  out  32  load data; combinational; 0 when not selected.
- `Sel`  out  1  combinational window hit; the bench uses it to mux ReadData against Data_Memory.
- `tx`  out  1  serial line, registered, idles high.

## Operation
- Register map, by `Address[3:2]`:
  - 0 DATA (W): push `WriteData[7:0]`.
  - 1 STATUS (R/W1C).
  - 2 DIV (R/W): `[15:0]`.
  - 3: reads 0, writes ignored.
- STATUS read format: bit0 busy (FSM not IDLE), bit1 full, bit2 empty, bit3 overflow (sticky), bits[7:4] FIFO count. Upper bits read 0.
- Writing STATUS with bit3=1 clears overflow. Other bits are read-only.
- A push when full is dropped and sets overflow. Exception: if the FSM pops in the same cycle, the push is accepted and overflow is not set.
- FSM states: IDLE → START → DATA (8 bits) → STOP → IDLE or START.
  - From IDLE or at the end of STOP: if the FIFO is non-empty, pop into the shift register and latch DIV into `div_q`, then go to START. Otherwise go to IDLE.
  - Back-to-back frames have no idle gap.
- Baud counter counts 0..`div_q`. At terminal count it advances the bit. DATA shifts right; the bit counter runs 0..7.
- Line levels: `tx` = 0 in START, `shift[0]` in DATA, 1 in STOP and IDLE.
- A DIV write mid-frame affects only the next frame.
- DIV = 0 is legal and gives 1 cycle per bit.

## Timing
- Reset values: `tx`=1, state IDLE, FIFO empty (count 0), overflow 0, DIV=`DEFAULT_DIV`, counters 0. `ReadData`/`Sel` follow their inputs combinationally.
- Register and FIFO writes take effect at the posedge on which `WE && Sel`.
- A byte written at edge N into an idle, empty block: the pop and the START entry occur at edge N+1, and `tx` falls at edge N+1.
- A frame lasts 10×(DIV+1) cycles (11× with parity).
- A loaded STATUS reflects state before the current edge. There is no read side effect.
- Reset asserted mid-frame: `tx` returns to 1 immediately (asynchronous), the FIFO is flushed, and DIV is restored to default.

## Configuration
- `MMIO_UART_TX_PARITY_EN` defined:
  - A PARITY state sits between DATA and STOP and drives even parity of the 8 data bits.
  - STATUS bit8 reads 1 to advertise the feature.
- Not defined: no PARITY state, 8N1 only, STATUS bit8 reads 0.

## Structure
- Package `mips_mmio_pkg` holds:
  - register offset constants (`UART_DATA_OFS`, `UART_STATUS_OFS`, `UART_DIV_OFS`)
  - STATUS bit-index constants
  - `uart_tx_state_t` enum (IDLE, START, DATA, PARITY, STOP)
- One sub-module, `mmio_tx_fifo`: synchronous FIFO with DEPTH entries, 8 bits wide, push/pop/full/empty/count, asynchronous active-low reset.
- Top level holds decode, CSRs, the baud counter and the FSM.

## Test plan
- Reset, then load STATUS at BASE+4 → ReadData = 32'h0000_0004 (empty); `tx`=1; DIV reads 433.
- Store DIV=3, then store 0x55 to DATA → `tx` falls one edge after the store, then shows 0,1,0,1,0,1,0,1,0,1 for 4 cycles each, then idle; busy clears after 40 cycles.
- Store 5 bytes back-to-back with DIV=0:
  - 1st byte pops at once; bytes 2–5 fill the FIFO, so there is no overflow.
  - A 6th store → overflow=1 and the byte is dropped.
  - Writing STATUS=0x8 clears overflow.
- Frames for bytes 0xA0 and 0x0F are contiguous: the STOP of 0xA0 is immediately followed by the START of 0x0F.
- Store DIV=7 mid-frame (DIV was 1) → the current frame keeps 2 cycles/bit and the next frame uses 8 cycles/bit.
- Assert `rst_n`=0 mid-DATA → `tx`=1 and count=0 immediately.
- With `MMIO_UART_TX_PARITY_EN`: byte 0x07 → parity bit 1 and an 11-bit frame; STATUS bit8=1.
